// File: rtl/reg_map_table.sv
// reg_map_table: architectural-to-physical rename map with checkpoint columns shared with the free list.
// Optional error checking is enabled by defining REG_MAP_TABLE_CHECKS_EN.
`default_nettype none

module reg_map_table #(
  parameter int NUM_ARCH_REGS      = 32,
  parameter int NUM_PHYS_REGS      = 64,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int ROB_DEPTH          = 16,
  parameter int LOG_NUM_ARCH_REGS  = $clog2(NUM_ARCH_REGS),
  parameter int LOG_NUM_PHYS_REGS  = $clog2(NUM_PHYS_REGS),
  parameter int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS),
  parameter int LOG_ROB_DEPTH      = $clog2(ROB_DEPTH)
) (
  input  logic                              CLK,
  input  logic                              nRST,
  output logic                              DUT_error,
  input  logic [LOG_NUM_ARCH_REGS-1:0]      source_arch_reg_tag_A,
  input  logic [LOG_NUM_ARCH_REGS-1:0]      source_arch_reg_tag_B,
  output logic [LOG_NUM_PHYS_REGS-1:0]      source_phys_reg_tag_A,
  output logic [LOG_NUM_PHYS_REGS-1:0]      source_phys_reg_tag_B,
  input  logic                              rename_valid,
  input  logic [LOG_NUM_ARCH_REGS-1:0]      rename_dest_arch_reg_tag,
  input  logic [LOG_NUM_PHYS_REGS-1:0]      rename_dest_phys_reg_tag,
  output logic [LOG_NUM_PHYS_REGS-1:0]      rename_old_dest_phys_reg_tag,
  input  logic                              revert_valid,
  input  logic [LOG_NUM_ARCH_REGS-1:0]      revert_dest_arch_reg_tag,
  input  logic [LOG_NUM_PHYS_REGS-1:0]      revert_safe_dest_phys_reg_tag,
  input  logic [LOG_NUM_PHYS_REGS-1:0]      revert_speculated_dest_phys_reg_tag,
  input  logic                              save_checkpoint_valid,
  input  logic [LOG_ROB_DEPTH-1:0]          save_checkpoint_ROB_index,
  output logic [LOG_CHECKPOINT_COLUMNS-1:0] save_checkpoint_safe_column,
  input  logic                              restore_checkpoint_valid,
  input  logic                              restore_checkpoint_speculate_failed,
  input  logic [LOG_ROB_DEPTH-1:0]          restore_checkpoint_ROB_index,
  input  logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_checkpoint_safe_column,
  output logic                              restore_checkpoint_success
);

  typedef logic [LOG_NUM_PHYS_REGS-1:0] ptag_t;

  ptag_t                              map_q [NUM_ARCH_REGS];
  ptag_t                              map_d [NUM_ARCH_REGS];
  ptag_t                              ckpt_map_q [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
  ptag_t                              ckpt_map_d [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
  logic [LOG_ROB_DEPTH-1:0]           ckpt_rob_q [CHECKPOINT_COLUMNS];
  logic [LOG_ROB_DEPTH-1:0]           ckpt_rob_d [CHECKPOINT_COLUMNS];
  logic [CHECKPOINT_COLUMNS-1:0]      ckpt_valid_q, ckpt_valid_d;
  logic [LOG_CHECKPOINT_COLUMNS-1:0]  tail_q, tail_d;

  logic restore_match;
  logic do_failed_restore;
  logic rename_blocked;
  logic do_rename;
  logic do_save;

  assign source_phys_reg_tag_A        = map_q[source_arch_reg_tag_A];
  assign source_phys_reg_tag_B        = map_q[source_arch_reg_tag_B];
  assign rename_old_dest_phys_reg_tag = map_q[rename_dest_arch_reg_tag];
  assign save_checkpoint_safe_column  = tail_q;

  assign restore_match = restore_checkpoint_valid
                       && ckpt_valid_q[restore_checkpoint_safe_column]
                       && (ckpt_rob_q[restore_checkpoint_safe_column] == restore_checkpoint_ROB_index);
  assign restore_checkpoint_success = restore_match;

  // Revert outranks a failed restore; either one drops any rename or save this cycle.
  assign do_failed_restore = restore_match && restore_checkpoint_speculate_failed && !revert_valid;
  assign rename_blocked    = revert_valid || do_failed_restore;
  assign do_rename         = rename_valid && !rename_blocked && (rename_dest_arch_reg_tag != '0);
  assign do_save           = save_checkpoint_valid && !rename_blocked;

  always_comb begin
    map_d        = map_q;
    ckpt_map_d   = ckpt_map_q;
    ckpt_rob_d   = ckpt_rob_q;
    ckpt_valid_d = ckpt_valid_q;
    tail_d       = tail_q;

    if (restore_match && !restore_checkpoint_speculate_failed)
      ckpt_valid_d[restore_checkpoint_safe_column] = 1'b0;

    if (revert_valid) begin
      if (revert_dest_arch_reg_tag != '0)
        map_d[revert_dest_arch_reg_tag] = revert_safe_dest_phys_reg_tag;
    end else if (do_failed_restore) begin
      map_d        = ckpt_map_q[restore_checkpoint_safe_column];
      tail_d       = restore_checkpoint_safe_column;
      ckpt_valid_d = '0;
    end else begin
      if (do_rename)
        map_d[rename_dest_arch_reg_tag] = rename_dest_phys_reg_tag;
      // The saved copy is the map before this cycle's rename.
      if (do_save) begin
        ckpt_map_d[tail_q]   = map_q;
        ckpt_rob_d[tail_q]   = save_checkpoint_ROB_index;
        ckpt_valid_d[tail_q] = 1'b1;
        tail_d               = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) map_q[i] <= ptag_t'(i);
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        ckpt_rob_q[c] <= '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) ckpt_map_q[c][i] <= '0;
      end
      ckpt_valid_q <= '0;
      tail_q       <= '0;
    end else begin
      map_q        <= map_d;
      ckpt_map_q   <= ckpt_map_d;
      ckpt_rob_q   <= ckpt_rob_d;
      ckpt_valid_q <= ckpt_valid_d;
      tail_q       <= tail_d;
    end
  end

`ifdef REG_MAP_TABLE_CHECKS_EN
  logic error_d, error_q;

  always_comb begin
    error_d = 1'b0;
    if (rename_valid && ((rename_dest_arch_reg_tag == '0) || rename_blocked))
      error_d = 1'b1;
    if (revert_valid && (map_q[revert_dest_arch_reg_tag] != revert_speculated_dest_phys_reg_tag))
      error_d = 1'b1;
    if (do_save && ckpt_valid_q[tail_q])
      error_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign DUT_error = error_q;
`else
  logic spec_tag_unused;
  assign spec_tag_unused = ^revert_speculated_dest_phys_reg_tag;
  assign DUT_error       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_map_table.sv
// Directed scoreboard bench for reg_map_table; error-flag expectations follow REG_MAP_TABLE_CHECKS_EN.
`default_nettype none

module tb_reg_map_table;

`ifdef REG_MAP_TABLE_CHECKS_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic       DUT_error;
  logic [4:0] source_arch_reg_tag_A, source_arch_reg_tag_B;
  logic [5:0] source_phys_reg_tag_A, source_phys_reg_tag_B;
  logic       rename_valid;
  logic [4:0] rename_dest_arch_reg_tag;
  logic [5:0] rename_dest_phys_reg_tag;
  logic [5:0] rename_old_dest_phys_reg_tag;
  logic       revert_valid;
  logic [4:0] revert_dest_arch_reg_tag;
  logic [5:0] revert_safe_dest_phys_reg_tag;
  logic [5:0] revert_speculated_dest_phys_reg_tag;
  logic       save_checkpoint_valid;
  logic [3:0] save_checkpoint_ROB_index;
  logic [1:0] save_checkpoint_safe_column;
  logic       restore_checkpoint_valid;
  logic       restore_checkpoint_speculate_failed;
  logic [3:0] restore_checkpoint_ROB_index;
  logic [1:0] restore_checkpoint_safe_column;
  logic       restore_checkpoint_success;

  reg_map_table dut (
    .CLK                                 (CLK),
    .nRST                                (nRST),
    .DUT_error                           (DUT_error),
    .source_arch_reg_tag_A               (source_arch_reg_tag_A),
    .source_arch_reg_tag_B               (source_arch_reg_tag_B),
    .source_phys_reg_tag_A               (source_phys_reg_tag_A),
    .source_phys_reg_tag_B               (source_phys_reg_tag_B),
    .rename_valid                        (rename_valid),
    .rename_dest_arch_reg_tag            (rename_dest_arch_reg_tag),
    .rename_dest_phys_reg_tag            (rename_dest_phys_reg_tag),
    .rename_old_dest_phys_reg_tag        (rename_old_dest_phys_reg_tag),
    .revert_valid                        (revert_valid),
    .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
    .revert_speculated_dest_phys_reg_tag (revert_speculated_dest_phys_reg_tag),
    .save_checkpoint_valid               (save_checkpoint_valid),
    .save_checkpoint_ROB_index           (save_checkpoint_ROB_index),
    .save_checkpoint_safe_column         (save_checkpoint_safe_column),
    .restore_checkpoint_valid            (restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column      (restore_checkpoint_safe_column),
    .restore_checkpoint_success          (restore_checkpoint_success)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic got(input int obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    rename_valid                        = 1'b0;
    rename_dest_arch_reg_tag            = '0;
    rename_dest_phys_reg_tag            = '0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = '0;
    revert_safe_dest_phys_reg_tag       = '0;
    revert_speculated_dest_phys_reg_tag = '0;
    save_checkpoint_valid               = 1'b0;
    save_checkpoint_ROB_index           = '0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = '0;
    restore_checkpoint_safe_column      = '0;
  endtask

  task automatic rename(input int arch, input int phys);
    rename_valid             = 1'b1;
    rename_dest_arch_reg_tag = 5'(arch);
    rename_dest_phys_reg_tag = 6'(phys);
  endtask

  task automatic restore(input int col, input int rob, input bit failed);
    restore_checkpoint_valid            = 1'b1;
    restore_checkpoint_safe_column      = 2'(col);
    restore_checkpoint_ROB_index        = 4'(rob);
    restore_checkpoint_speculate_failed = failed;
  endtask

  task automatic save(input int rob);
    save_checkpoint_valid     = 1'b1;
    save_checkpoint_ROB_index = 4'(rob);
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    source_arch_reg_tag_A = 5'd7;
    source_arch_reg_tag_B = 5'd0;
    #12 nRST = 1'b1;
    settle();

    // Reset state
    expect_val("reset_err", 0);       got(DUT_error);
    expect_val("reset_tail", 0);      got(save_checkpoint_safe_column);
    expect_val("reset_map7", 7);      got(source_phys_reg_tag_A);
    expect_val("reset_map0", 0);      got(source_phys_reg_tag_B);
    restore(0, 0, 1'b0);
    settle();
    expect_val("reset_col0_invalid", 0); got(restore_checkpoint_success);
    idle();

    // Rename 7 -> 40: old mapping and same-cycle read are pre-rename
    tick();
    rename(7, 40);
    expect_val("rename7_old", 7);     expect_val("rename7_same_cycle", 7);
    settle();
    got(rename_old_dest_phys_reg_tag); got(source_phys_reg_tag_A);
    tick();
    idle();
    expect_val("rename7_next", 40);   expect_val("rename7_err", 0);
    settle();
    got(source_phys_reg_tag_A);       got(DUT_error);

    // Rename 3 -> 33 with save to column 0, rename 3 -> 34, failed restore of column 0
    tick();
    rename(3, 33); save(5);
    expect_val("save_tail0", 0);
    settle();
    got(save_checkpoint_safe_column);
    tick();
    idle();
    rename(3, 34);
    source_arch_reg_tag_A = 5'd3;
    expect_val("map3_33", 33);        expect_val("tail_after_save", 1);
    settle();
    got(source_phys_reg_tag_A);       got(save_checkpoint_safe_column);
    tick();
    idle();
    restore(0, 5, 1'b1);
    expect_val("failed_restore_success", 1);
    settle();
    got(restore_checkpoint_success);
    tick();
    idle();
    source_arch_reg_tag_B = 5'd7;
    expect_val("restored_map3", 3);   expect_val("restored_map7", 40);
    expect_val("restored_tail", 0);   expect_val("restore_err", 0);
    settle();
    got(source_phys_reg_tag_A);       got(source_phys_reg_tag_B);
    got(save_checkpoint_safe_column); got(DUT_error);
    restore(0, 5, 1'b0);
    expect_val("col0_invalidated", 0);
    settle();
    got(restore_checkpoint_success);
    idle();

    // Fill columns 0-3, then a fifth save overwrites column 0
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      save(i + 1);
      expect_val($sformatf("fill_tail%0d", i), i);
      settle();
      got(save_checkpoint_safe_column);
    end
    tick();
    idle();
    save(9);
    expect_val("fifth_save_tail", 0); expect_val("fill_err", 0);
    settle();
    got(save_checkpoint_safe_column); got(DUT_error);
    tick();
    idle();
    expect_val("overflow_err", ERR_EN);
    settle();
    got(DUT_error);
    restore(0, 1, 1'b1);
    expect_val("mismatch_success", 0);
    settle();
    got(restore_checkpoint_success);
    tick();
    idle();
    source_arch_reg_tag_A = 5'd7;
    expect_val("mismatch_map7", 40);  expect_val("mismatch_tail", 1);
    settle();
    got(source_phys_reg_tag_A);       got(save_checkpoint_safe_column);
    restore(0, 9, 1'b0);
    expect_val("col0_overwritten", 1);
    settle();
    got(restore_checkpoint_success);
    idle();

    // Rename 5 -> 50 then revert with correct and wrong speculated tags
    tick();
    rename(5, 50);
    tick();
    idle();
    source_arch_reg_tag_A = 5'd5;
    expect_val("map5_50", 50);
    settle();
    got(source_phys_reg_tag_A);
    revert_valid = 1'b1; revert_dest_arch_reg_tag = 5'd5;
    revert_safe_dest_phys_reg_tag = 6'd5; revert_speculated_dest_phys_reg_tag = 6'd50;
    tick();
    idle();
    expect_val("revert_map5", 5);     expect_val("revert_ok_err", 0);
    settle();
    got(source_phys_reg_tag_A);       got(DUT_error);
    rename(5, 50);
    tick();
    idle();
    revert_valid = 1'b1; revert_dest_arch_reg_tag = 5'd5;
    revert_safe_dest_phys_reg_tag = 6'd5; revert_speculated_dest_phys_reg_tag = 6'd49;
    tick();
    idle();
    expect_val("revert_bad_err", ERR_EN); expect_val("revert_bad_map5", 5);
    settle();
    got(DUT_error);                   got(source_phys_reg_tag_A);

    // Correct restore of column 1 (ROB 2) alongside rename 9 -> 45
    restore(1, 2, 1'b0); rename(9, 45);
    source_arch_reg_tag_A = 5'd9;
    expect_val("correct_restore_success", 1);
    settle();
    got(restore_checkpoint_success);
    tick();
    idle();
    expect_val("map9_45", 45);        expect_val("correct_restore_err", 0);
    settle();
    got(source_phys_reg_tag_A);       got(DUT_error);
    restore(1, 2, 1'b0);
    expect_val("col1_invalid", 0);
    settle();
    got(restore_checkpoint_success);
    restore(2, 3, 1'b0);
    expect_val("col2_untouched", 1);
    settle();
    got(restore_checkpoint_success);
    restore(3, 4, 1'b0);
    expect_val("col3_untouched", 1);
    settle();
    got(restore_checkpoint_success);
    idle();

    // Rename to arch 0 is ignored with an error
    rename(0, 12);
    tick();
    idle();
    source_arch_reg_tag_A = 5'd0;
    expect_val("arch0_err", ERR_EN);  expect_val("arch0_map", 0);
    settle();
    got(DUT_error);                   got(source_phys_reg_tag_A);

    // Asynchronous reset mid-sequence
    rename(11, 20);
    tick();
    idle();
    source_arch_reg_tag_A = 5'd11;
    expect_val("map11_20", 20);
    settle();
    got(source_phys_reg_tag_A);
    nRST = 1'b0;
    source_arch_reg_tag_B = 5'd7;
    restore(2, 3, 1'b0);
    expect_val("areset_map11", 11);   expect_val("areset_map7", 7);
    expect_val("areset_success", 0);  expect_val("areset_tail", 0);
    expect_val("areset_err", 0);
    #1;
    got(source_phys_reg_tag_A);       got(source_phys_reg_tag_B);
    got(restore_checkpoint_success);  got(save_checkpoint_safe_column);
    got(DUT_error);
    idle();
    #1 nRST = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/reg_map_table.md
# reg_map_table

Architectural-to-physical register map table for the dispatch unit: it renames destination registers and reads current source mappings. It sits beside the physical register free list. Each rename consumes the free list's dequeued tag and returns the displaced old mapping, which the ROB later frees back to the list. It keeps checkpoint copies of the map, indexed by the same checkpoint column numbering the free list uses, so that both blocks save and restore together.

## Interface
Parameters:
- NUM_ARCH_REGS, 32, architectural registers (LOG_NUM_ARCH_REGS = 5)
- NUM_PHYS_REGS, 64, physical registers (LOG_NUM_PHYS_REGS = 6)
- CHECKPOINT_COLUMNS, 4, saved map copies (LOG = 2)
- ROB_DEPTH, 16, ROB entries (LOG = 4)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- DUT_error  out  1  registered error flag
- source_arch_reg_tag_A / _B  in  5  source read addresses
- source_phys_reg_tag_A / _B  out  6  current mappings (combinational)
- rename_valid  in  1  rename a destination this cycle
- rename_dest_arch_reg_tag  in  5  destination arch reg
- rename_dest_phys_reg_tag  in  6  new tag (free list dequeue tag)
- rename_old_dest_phys_reg_tag  out  6  current mapping of rename_dest_arch_reg_tag (combinational, to ROB)
- revert_valid  in  1  undo one rename (ROB walk-back)
- revert_dest_arch_reg_tag  in  5  arch reg to revert
- revert_safe_dest_phys_reg_tag  in  6  mapping to reinstate
- revert_speculated_dest_phys_reg_tag  in  6  mapping expected now
- save_checkpoint_valid  in  1  save map copy
- save_checkpoint_ROB_index  in  4  tag stored with copy
- save_checkpoint_safe_column  out  2  column written by a save this cycle (= tail)
- restore_checkpoint_valid  in  1  branch resolved
- restore_checkpoint_speculate_failed  in  1  1 = restore map, 0 = discard column
- restore_checkpoint_ROB_index  in  4  tag to match
- restore_checkpoint_safe_column  in  2  column to restore or discard
- restore_checkpoint_success  out  1  valid and ROB-index match (combinational)

## Operation
- State: map[NUM_ARCH_REGS] of 6-bit tags. Each column holds {valid, ROB_index, map copy}. There is a 2-bit checkpoint tail.
- Reset: map[i] = i, all columns invalid, tail = 0, DUT_error = 0.
- Rename: map[dest] <= rename_dest_phys_reg_tag. Arch reg 0 is never remapped; a rename to reg 0 is ignored and raises an error.
- Revert: map[revert_dest] <= safe tag. Error if map[revert_dest] != speculated tag.
- Restore with speculate_failed = 1 and a match:
  - map <= column copy
  - tail <= safe column
  - all columns invalidated, including the safe column
  - success = 1
- Restore with speculate_failed = 0 and a match: that column is invalidated and success = 1. This case runs in parallel with every other operation.
- Restore with no match: no state change and success = 0.
- Save:
  - column[tail] <= {1, ROB_index, map as it stands before this cycle's rename}
  - tail wraps to tail + 1 mod 4
  - Error if column[tail] was already valid; it is overwritten anyway.
- Priority: revert > failed restore > save/rename. Save and rename in the same cycle are both applied. A rename coinciding with a revert or failed restore is dropped and raises an error.

## Timing
- All reads and success are combinational on current state. Map updates are visible the cycle after.
- Source or old-dest reads in the same cycle as a rename of that register return the old mapping.
- DUT_error is asserted the cycle after the offending event and lasts one cycle per event.
- Checkpoint tail wraps from 3 to 0. Four consecutive saves without resolution fill all columns; a fifth save raises an error.
- Asserting nRST mid-operation asynchronously returns all state to reset values.

## Configuration
- REG_MAP_TABLE_CHECKS_EN defined: all error checks above drive DUT_error.
- Undefined: DUT_error tied 0, no check logic. Functional behaviour, including dropped operations and overwrites, is identical.

## Test plan
- Reset, then read arch 7 -> phys 7; rename arch 7 to 40 -> old dest = 7, next-cycle read = 40.
- Rename arch 3 to 33 with save in the same cycle (tail 0); rename arch 3 to 34; failed restore on column 0 with a matching ROB index -> success = 1, arch 3 reads 3, tail = 0, all columns invalid.
- Save columns 0-3; fifth save -> DUT_error the next cycle, column 0 overwritten; restore with a mismatched ROB index -> success = 0, no change.
- Rename arch 5 to 50, then revert arch 5 with safe = 5, speculated = 50 -> arch 5 reads 5, no error; repeat with speculated = 49 -> DUT_error.
- Correct restore on column 1 while renaming arch 9 to 45 -> column 1 invalid, arch 9 = 45, other columns untouched.
- Rename to arch 0 -> arch 0 stays 0, DUT_error; assert nRST mid-sequence -> identity map, success = 0.
